hamming_serial_rx: RTL
======================

Name: hamming_serial_rx

Overview:
- Serial receive end of the Hamming(7,4) link.
- Collects a 7-bit codeword one bit per `shift` strobe, framed by `frame_start`, latches it and computes the syndrome.
- Corrects any single-bit error and presents the 4 data bits with a one-cycle `valid` pulse.
- Sits downstream of the parallel-to-serial stage that follows `encoding`; complements the parallel `decoding` block for serial links.

Parameters:
- M, 4, data bits per codeword; only 4 is supported, and codeword width N = 7 is derived.
- GAP_MAX, 16, maximum clock cycles allowed between consecutive `shift` strobes inside a frame before the partial frame is aborted.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- shift  input  1  bit strobe; `bit_in` is sampled on a rising edge of clk where shift=1.
- frame_start  input  1  qualifies the current shift as codeword bit 0 (position 1); ignored when shift=0.
- bit_in  input  1  serial codeword bit, sent in order index 0..6 = Hamming positions 1..7 (p1 p2 d1 p4 d2 d3 d4).
- bits_out  output  [0:M-1]  corrected data {d1,d2,d3,d4} = positions 3,5,6,7.
- syndrome  output  3  {s4,s2,s1}; 0 = no error, else the 1-based position of the flipped bit.
- valid  output  1  one-cycle pulse; bits_out, syndrome and corrected are new.
- corrected  output  1  syndrome != 0 for the word presented with valid.
- frame_err  output  1  one-cycle pulse when a partial frame is aborted.
- busy  output  1  high while a frame is partially received (bit count 1..6).

Behaviour:
- Reset (sync, highest priority) clears: bit count=0, shift register=0, hold register=0, pending=0, gap counter=0, bits_out=0, syndrome=0, valid=0, corrected=0, frame_err=0, busy=0.
- Bit counter cnt takes values 0..6; busy = (cnt != 0).
- shift & frame_start:
  - Store bit_in at index 0, cnt<=1, gap counter cleared.
  - Always restarts the frame, even mid-frame.
  - The abandoned partial frame produces no frame_err.
- shift & !frame_start & cnt in 1..5: store at index cnt, cnt<=cnt+1, gap counter cleared.
- shift & !frame_start & cnt==6:
  - Seventh bit. The full codeword (shift register with bit_in at index 6) goes into the hold register.
  - cnt<=0, pending<=1.
- shift & !frame_start & cnt==0: bit ignored; no flags.
- Decode, on the edge after pending=1:
  - Compute s1 = c1^c3^c5^c7, s2 = c2^c3^c6^c7, s4 = c4^c5^c6^c7 from the hold register.
  - If s != 0, invert hold bit at position s.
  - Register bits_out, syndrome and corrected; assert valid for exactly one cycle; pending<=0.
  - Latency: valid is high in the 2nd cycle after the edge capturing the 7th bit.
- Outputs bits_out, syndrome and corrected hold their values until the next valid. valid and frame_err are single-cycle pulses.
- Double-bit errors are miscorrected (nonzero syndrome, wrong data). This is inherent to Hamming(7,4) and is not flagged.
- Gap timeout:
  - While cnt in 1..6 and shift=0, the gap counter increments each cycle.
  - When it reaches GAP_MAX: cnt<=0, gap counter<=0, frame_err pulses one cycle, shift register contents are discarded.
  - A shift arriving in the same cycle as the timeout wins; no frame_err.
- Simultaneous events:
  - A frame_start shift in the decode cycle is accepted normally. Decode uses only the hold register, so back-to-back frames with no idle cycle are supported.
  - Reset during pending suppresses valid.

Test Plan:
- Clean frame: data 1010 → codeword bits 1,0,1,1,0,1,0 on 7 consecutive shifts with frame_start on bit 0 → valid 2 cycles after 7th edge, bits_out=1010, syndrome=0, corrected=0.
- Single error: same frame with bit index 4 inverted (1,0,1,1,1,1,0) → bits_out=1010, syndrome=5, corrected=1. Repeat flipping each of the 7 positions → syndrome equals position each time, bits_out=1010.
- Spaced shifts: shifts every 2nd cycle (as from a divided strobe), data 0110 → bits_out=0110, valid exactly one cycle, busy high from bit 0 capture until 7th capture.
- Timeout: 3 bits then no shift for GAP_MAX=16 cycles → frame_err pulse on cycle 16, busy→0, no valid. Subsequent full frame decodes correctly.
- Restart and back-to-back: frame_start reasserted after 4 bits → old bits dropped, new frame decodes, no frame_err. Two frames with frame_start in the decode cycle → two valid pulses 7 cycles apart with the correct data each.
- Reset: reset asserted between 7th bit and valid → no valid. After reset all outputs 0; stray shift without frame_start is ignored.

Source files
------------

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver.
// Shifts in a 7-bit codeword one bit per strobe, then decodes it from a hold
// register so the next frame can start shifting in on the decode edge.
// Single-bit errors are corrected. A frame is aborted if the gap between
// strobes grows too long.

module hamming_serial_rx #(
    parameter int M       = 4,   // data bits per codeword; only 4 is supported
    parameter int GAP_MAX = 16   // max idle cycles between strobes inside a frame
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift,
    input  logic         frame_start,
    input  logic         bit_in,
    output logic [0:M-1] bits_out,
    output logic [2:0]   syndrome,
    output logic         valid,
    output logic         corrected,
    output logic         frame_err,
    output logic         busy
);

    localparam int N     = M + 3;
    localparam int GAP_W = $clog2(GAP_MAX + 1);

    // Bits 0..5 of the frame being received; bit 6 goes straight into hold_reg.
    logic [N-2:0]     shift_reg;
    // Complete codeword, indexed by Hamming position 1..7.
    logic [N:1]       hold_reg;
    logic [2:0]       cnt;
    logic             pending;
    // Idle cycles still allowed before the partial frame is dropped.
    logic [GAP_W-1:0] gap_left;

    logic [2:0]       syn_c;
    logic [N:1]       fixed_c;
    logic [0:M-1]     data_c;

    assign busy = (cnt != 3'd0);

    // Syndrome and single-bit correction of the held codeword.
    always_comb begin
        syn_c[0] = hold_reg[1] ^ hold_reg[3] ^ hold_reg[5] ^ hold_reg[7];
        syn_c[1] = hold_reg[2] ^ hold_reg[3] ^ hold_reg[6] ^ hold_reg[7];
        syn_c[2] = hold_reg[4] ^ hold_reg[5] ^ hold_reg[6] ^ hold_reg[7];
        fixed_c  = hold_reg;
        for (int p = 1; p <= N; p++) begin
            if (syn_c == 3'(p)) begin
                fixed_c[p] = ~hold_reg[p];
            end
        end
        data_c = {fixed_c[3], fixed_c[5], fixed_c[6], fixed_c[7]};
    end

    // Bit collection, gap timeout and registered decode outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 3'd0;
            shift_reg <= '0;
            hold_reg  <= '0;
            pending   <= 1'b0;
            gap_left  <= '0;
            bits_out  <= '0;
            syndrome  <= 3'd0;
            valid     <= 1'b0;
            corrected <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;

            // Decode works only from hold_reg, so it never collides with
            // a new frame shifting in on the same edge.
            if (pending) begin
                bits_out  <= data_c;
                syndrome  <= syn_c;
                corrected <= (syn_c != 3'd0);
                valid     <= 1'b1;
                pending   <= 1'b0;
            end

            if (shift && frame_start) begin
                // A frame start always restarts silently, even mid-frame.
                shift_reg[0] <= bit_in;
                cnt          <= 3'd1;
                gap_left     <= GAP_W'(GAP_MAX - 1);
            end else if (shift && cnt != 3'd0) begin
                gap_left <= GAP_W'(GAP_MAX - 1);
                if (cnt == 3'd6) begin
                    hold_reg <= {bit_in, shift_reg};
                    cnt      <= 3'd0;
                    pending  <= 1'b1;
                end else begin
                    shift_reg[cnt] <= bit_in;
                    cnt            <= cnt + 3'd1;
                end
            end else if (!shift && cnt != 3'd0) begin
                if (gap_left == '0) begin
                    cnt       <= 3'd0;
                    gap_left  <= '0;
                    shift_reg <= '0;
                    frame_err <= 1'b1;
                end else begin
                    gap_left <= gap_left - 1'b1;
                end
            end
        end
    end

endmodule
